// File: rtl/regbank_dump_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regbank_dump_pkg
//  Description : Shared types and default sizes for the register-bank dump
//                engine and the datapath that owns the register bank.
//  Revision    : 1.0 - initial release
// ============================================================================
package regbank_dump_pkg;

    // Default register-bank geometry, shared with datapath
    localparam int c_XLEN  = 32;
    localparam int c_NREGS = 32;

    // Dump engine states, explicitly encoded
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_READ = 3'd2,
        ST_SEND = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage : regbank_dump_pkg
`default_nettype wire

// File: rtl/regbank_dump_counter.sv
`default_nettype none
// ============================================================================
//  Module      : dump_counter
//  Description : Up-counter with synchronous clear, count enable and a
//                terminal-count flag raised when the count equals LAST.
//  Revision    : 1.0 - initial release
// ============================================================================
module dump_counter #(
    parameter int WIDTH = 5,
    parameter int LAST  = 31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_count;

    // Count register: clear wins over enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == WIDTH'(LAST));

endmodule : dump_counter
`default_nettype wire

// File: rtl/regbank_dump.sv
`default_nettype none
// ============================================================================
//  Module      : regbank_dump
//  Description : Waits for core halt (or a cycle timeout), then walks the
//                register bank through a read port and streams each
//                (index, value) pair over valid/ready, with optional
//                skip-zero filtering and a running checksum.
//  Revision    : 1.0 - initial release
// ============================================================================
module regbank_dump
    import regbank_dump_pkg::*;
#(
    parameter int XLEN    = c_XLEN,
    parameter int NREGS   = c_NREGS,
    parameter int TIMEOUT = 100,
    parameter int IDXW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            skip_zero,
    input  logic            halt,
    output logic [IDXW-1:0] rd_addr,
    input  logic [XLEN-1:0] rd_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IDXW-1:0] out_idx,
    output logic [XLEN-1:0] out_data,
    output logic            busy,
    output logic            done,
    output logic            timed_out,
    output logic [XLEN-1:0] checksum
);

    // Wait counter must hold TIMEOUT-1; keep at least one bit for TIMEOUT==1
    localparam int c_WAITW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e             r_state;
    state_e             w_next;

    logic               r_skip;
    logic               r_timed_out;
    logic [XLEN-1:0]    r_checksum;
    logic [IDXW-1:0]    r_out_idx;
    logic [XLEN-1:0]    r_out_data;

    logic               w_wait_clr;
    logic               w_wait_en;
    logic               w_wait_tc;
    logic [c_WAITW-1:0] w_wait_cnt;

    logic               w_idx_clr;
    logic               w_idx_en;
    logic               w_idx_tc;
    logic [IDXW-1:0]    w_idx;

    logic               w_drop;
    logic               w_hs;

    // A register read in READ is dropped when filtering is on and it reads 0
    assign w_drop = r_skip && (rd_data == '0);
    assign w_hs   = (r_state == ST_SEND) && out_ready;

    // Halt-wait cycle counter
    dump_counter #(
        .WIDTH (c_WAITW),
        .LAST  (TIMEOUT - 1)
    ) u_wait_cnt (
        .clk     (clk),
        .rst     (reset),
        .i_clr   (w_wait_clr),
        .i_en    (w_wait_en),
        .o_count (w_wait_cnt),
        .o_tc    (w_wait_tc)
    );

    // Register scan index; stops at NREGS-1, never wraps
    dump_counter #(
        .WIDTH (IDXW),
        .LAST  (NREGS - 1)
    ) u_idx_cnt (
        .clk     (clk),
        .rst     (reset),
        .i_clr   (w_idx_clr),
        .i_en    (w_idx_en),
        .o_count (w_idx),
        .o_tc    (w_idx_tc)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; halt beats the timeout in the same cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next = ST_WAIT;
            ST_WAIT: if (halt || w_wait_tc) w_next = ST_READ;
            ST_READ: begin
                if (!w_drop)      w_next = ST_SEND;
                else if (w_idx_tc) w_next = ST_DONE;
            end
            ST_SEND: if (out_ready) w_next = w_idx_tc ? ST_DONE : ST_READ;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // State-decoded outputs and counter controls
    always_comb begin
        busy       = (r_state != ST_IDLE);
        done       = (r_state == ST_DONE);
        out_valid  = (r_state == ST_SEND);
        w_wait_clr = (r_state == ST_IDLE) && start;
        w_wait_en  = (r_state == ST_WAIT) && !halt && !w_wait_tc;
        // Index is held at 0 throughout WAIT so READ always starts at x0
        w_idx_clr  = (r_state == ST_WAIT);
        w_idx_en   = (((r_state == ST_READ) && w_drop) || w_hs) && !w_idx_tc;
    end

    // Beat capture, sticky timeout flag and running checksum
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_skip      <= 1'b0;
            r_timed_out <= 1'b0;
            r_checksum  <= '0;
            r_out_idx   <= '0;
            r_out_data  <= '0;
        end else begin
            if ((r_state == ST_IDLE) && start) begin
                r_skip      <= skip_zero;
                r_timed_out <= 1'b0;
                r_checksum  <= '0;
            end
            if ((r_state == ST_WAIT) && !halt && w_wait_tc) begin
                r_timed_out <= 1'b1;
            end
            if (r_state == ST_READ) begin
                r_out_idx  <= w_idx;
                r_out_data <= rd_data;
            end
            if (w_hs) begin
                r_checksum <= r_checksum + r_out_data;
            end
        end
    end

    assign rd_addr   = w_idx;
    assign out_idx   = r_out_idx;
    assign out_data  = r_out_data;
    assign timed_out = r_timed_out;
    assign checksum  = r_checksum;

endmodule : regbank_dump
`default_nettype wire

// File: tb/tb_regbank_dump.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regbank_dump
//  Description : Directed self-checking bench for regbank_dump.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regbank_dump;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        skip_zero;
    logic        halt;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_idx;
    logic [31:0] out_data;
    logic        busy;
    logic        done;
    logic        timed_out;
    logic [31:0] checksum;

    logic [31:0] bank [32];
    assign rd_data = bank[rd_addr];

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    bit bp_mode = 1'b0;
    bit stable_err = 1'b0;

    logic [4:0]  got_idx[$];
    logic [31:0] got_data[$];
    logic [4:0]  exp_idx[$];
    logic [31:0] exp_data[$];

    logic        prev_stall;
    logic [4:0]  prev_idx;
    logic [31:0] prev_data;

    regbank_dump u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .skip_zero (skip_zero),
        .halt      (halt),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done),
        .timed_out (timed_out),
        .checksum  (checksum)
    );

    always #5 clk = ~clk;

    // Beat collector, stall-stability watcher and done counter, on the falling edge
    always @(negedge clk) begin
        if (reset) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (!out_valid || out_idx !== prev_idx || out_data !== prev_data))
                stable_err <= 1'b1;
            if (out_valid && out_ready) begin
                got_idx.push_back(out_idx);
                got_data.push_back(out_data);
            end
            if (done) done_cnt <= done_cnt + 1;
            prev_stall <= out_valid && !out_ready;
            prev_idx   <= out_idx;
            prev_data  <= out_data;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bp_mode) out_ready = ($urandom_range(0, 9) < 3);
    endtask

    task automatic do_start(input bit skip);
        got_idx.delete();
        got_data.delete();
        skip_zero = skip;
        start = 1'b1;
        tick();
        start = 1'b0;
        skip_zero = 1'b0;
    endtask

    task automatic do_halt();
        halt = 1'b1;
        tick();
        halt = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n = 0;
        while (done !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, done, 1'b1);
        tick();
    endtask

    task automatic build_exp(input bit skip);
        exp_idx.delete();
        exp_data.delete();
        for (int i = 0; i < 32; i++) begin
            if (!(skip && bank[i] == 32'd0)) begin
                exp_idx.push_back(5'(i));
                exp_data.push_back(bank[i]);
            end
        end
    endtask

    task automatic compare_beats(input string tag);
        check({tag, "_beats"}, got_idx.size(), exp_idx.size());
        for (int i = 0; i < exp_idx.size(); i++) begin
            if (i < got_idx.size()) begin
                check($sformatf("%s_idx%0d", tag, i), got_idx[i], exp_idx[i]);
                check($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
            end
        end
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < 32; i++) bank[i] = 32'(i * 3);
    endtask

    initial begin
        int n;
        int dc;
        reset = 1'b1;
        start = 1'b0;
        skip_zero = 1'b0;
        halt = 1'b0;
        out_ready = 1'b1;
        fill_ramp();

        // ---------------- reset state ----------------
        repeat (3) tick();
        check("rst_busy", busy, 1'b0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_idx", out_idx, 5'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_addr", rd_addr, 5'd0);
        check("rst_tmo", timed_out, 1'b0);
        check("rst_csum", checksum, 32'd0);
        reset = 1'b0;
        tick();

        // ---------------- halt before timeout, exact timing ----------------
        do_start(1'b0);
        check("a_busy_after_start", busy, 1'b1);
        repeat (9) tick();
        do_halt();
        check("a_read_no_valid", out_valid, 1'b0);
        tick();
        check("a_first_valid", out_valid, 1'b1);
        check("a_first_idx", out_idx, 5'd0);
        repeat (62) tick();
        check("a_done_not_early", done, 1'b0);
        tick();
        check("a_done_pulse", done, 1'b1);
        tick();
        check("a_done_one_cycle", done, 1'b0);
        check("a_idle", busy, 1'b0);
        check("a_csum", checksum, 32'h5D0);
        check("a_tmo", timed_out, 1'b0);
        build_exp(1'b0);
        compare_beats("a");

        // ---------------- timeout path ----------------
        do_start(1'b0);
        n = 0;
        while (!out_valid && n < 500) begin
            tick();
            n++;
        end
        check("t_first_valid_latency", n, 101);
        check("t_tmo_set", timed_out, 1'b1);
        wait_done("t", 200);
        check("t_csum", checksum, 32'h5D0);
        check("t_tmo_sticky", timed_out, 1'b1);
        compare_beats("t");

        // ---------------- skip zero ----------------
        for (int i = 0; i < 32; i++) bank[i] = 32'd0;
        bank[5]  = 32'hDEADBEEF;
        bank[31] = 32'd1;
        do_start(1'b1);
        check("s_tmo_cleared", timed_out, 1'b0);
        check("s_csum_cleared", checksum, 32'd0);
        repeat (3) tick();
        do_halt();
        wait_done("s", 200);
        check("s_csum", checksum, 32'hDEADBEF0);
        check("s_tmo", timed_out, 1'b0);
        build_exp(1'b1);
        compare_beats("s");

        // ---------------- backpressure ----------------
        fill_ramp();
        stable_err = 1'b0;
        do_start(1'b0);
        repeat (4) tick();
        do_halt();
        bp_mode = 1'b1;
        wait_done("b", 5000);
        bp_mode = 1'b0;
        out_ready = 1'b1;
        check("b_csum", checksum, 32'h5D0);
        check("b_stable", stable_err, 1'b0);
        build_exp(1'b0);
        compare_beats("b");

        // ---------------- reset mid-dump ----------------
        do_start(1'b0);
        repeat (2) tick();
        do_halt();
        n = 0;
        while (!(out_valid && out_idx == 5'd12) && n < 200) begin
            tick();
            n++;
        end
        check("r_reached_beat12", out_valid && out_idx == 5'd12, 1'b1);
        dc = done_cnt;
        #2 reset = 1'b1;
        #1;
        check("r_busy", busy, 1'b0);
        check("r_valid", out_valid, 1'b0);
        check("r_idx", out_idx, 5'd0);
        check("r_data", out_data, 32'd0);
        check("r_addr", rd_addr, 5'd0);
        check("r_csum", checksum, 32'd0);
        check("r_done", done, 1'b0);
        repeat (2) tick();
        check("r_no_done", done_cnt, dc);
        reset = 1'b0;
        tick();
        do_start(1'b0);
        repeat (2) tick();
        do_halt();
        wait_done("r2", 200);
        check("r2_csum", checksum, 32'h5D0);
        compare_beats("r2");

        // ---------------- start ignored during SEND ----------------
        do_start(1'b0);
        repeat (2) tick();
        do_halt();
        n = 0;
        while (!(out_valid && out_idx == 5'd5) && n < 200) begin
            tick();
            n++;
        end
        out_ready = 1'b0;
        check("i_reached_beat5", out_valid && out_idx == 5'd5, 1'b1);
        repeat (2) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("i_still_valid", out_valid, 1'b1);
        check("i_idx_held", out_idx, 5'd5);
        check("i_data_held", out_data, 32'd15);
        check("i_csum_kept", checksum, 32'h1E);
        out_ready = 1'b1;
        wait_done("i", 200);
        check("i_csum", checksum, 32'h5D0);
        compare_beats("i");

        check("done_count", done_cnt, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_regbank_dump
`default_nettype wire
